bin2bcd_seq: RTL and testbench

- Sequential binary-to-packed-BCD converter using the shift-add-3 (double-dabble) method, one input bit per cycle.
- Sits directly upstream of the 8-digit seven-segment scan driver. Its registered 32-bit packed-BCD output feeds that driver's 32-bit data input, so CPU values display in decimal.
- Values that do not fit in 8 decimal digits are replaced by an all-'E' error pattern.

---
 rtl/bin2bcd_seq.sv | 126 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-add-3, one bit per clock).
// Results that need more than 8 decimal digits are replaced by an all-'E' pattern.
module bin2bcd_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      bcd_out,
    output logic             out_valid,
    output logic             overflow
);

    localparam int unsigned SHR_W   = 32;
    localparam int unsigned DIGITS  = 10;
    localparam int unsigned SCR_W   = 4 * DIGITS;
    localparam int unsigned OUT_W   = 32;
    localparam int unsigned CNT_W   = 5;
    localparam logic [OUT_W-1:0] ERR_PATTERN = 32'hEEEE_EEEE;
    localparam logic [CNT_W-1:0] LAST_STEP   = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SHR_W-1:0]   shreg_q, shreg_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [SCR_W-1:0]   adj_c;

    // Add 3 to each digit >= 5; each digit is adjusted on its own, with no carry.
    function automatic logic [SCR_W-1:0] add3_digits(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        logic [3:0]       d;
        r = s;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = s[4*i +: 4];
            if (d >= 4'd5) begin
                r[4*i +: 4] = d + 4'd3;
            end
        end
        return r;
    endfunction

    assign adj_c = add3_digits(scratch_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d   = SHR_W'(bin_in);
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Adjust first, then shift the shreg MSB into scratch bit 0.
                scratch_d = {adj_c[SCR_W-2:0], shreg_q[SHR_W-1]};
                shreg_d   = {shreg_q[SHR_W-2:0], 1'b0};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (scratch_q[SCR_W-1:OUT_W] != '0) begin
                    ovf_d = 1'b1;
                    bcd_d = ERR_PATTERN;
                end else begin
                    ovf_d = 1'b0;
                    bcd_d = scratch_q[OUT_W-1:0];
                end
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign bcd_out   = bcd_q;
    assign overflow  = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
module tb_bin2bcd_seq;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rstn;
    logic [WIDTH-1:0] bin_in;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      bcd_out;
    logic             out_valid;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    bin2bcd_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Clock until out_valid rises; returns clocks taken (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Full conversion: accept, wait, check result, latency and pulse width.
    task automatic convert(input string tag, input logic [31:0] val,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        int n;
        bin_in   = val;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'd33);
        check({tag, "_bcd"}, bcd_out, exp_bcd);
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        tick();
        check({tag, "_valid_pulse"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic seen;
        rstn     = 1'b0;
        in_valid = 1'b0;
        bin_in   = '0;
        #3;
        check("rst_bcd", bcd_out, 32'h0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        tick();
        rstn = 1'b1;
        tick();

        convert("c12345678", 32'd12345678, 32'h1234_5678, 1'b0);
        convert("c0", 32'd0, 32'h0000_0000, 1'b0);
        convert("c99999999", 32'd99_999_999, 32'h9999_9999, 1'b0);
        convert("c1e8", 32'd100_000_000, 32'hEEEE_EEEE, 1'b1);
        convert("cmax", 32'hFFFF_FFFF, 32'hEEEE_EEEE, 1'b1);

        // Asynchronous reset 10 clocks into SHIFT aborts everything.
        bin_in   = 32'd5555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #2 rstn = 1'b0;
        #1;
        check("abort_bcd", bcd_out, 32'h0);
        check("abort_ovf", 32'(overflow), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        tick();
        rstn = 1'b1;
        check("abort_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_pulse", 32'(seen), 32'd0);

        // Request during SHIFT is ignored; held request is taken at E34.
        bin_in   = 32'd42;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        bin_in   = 32'd7;
        in_valid = 1'b1;
        wait_done(n);
        check("busy_latency", 32'(n), 32'd30);
        check("busy_bcd", bcd_out, 32'h0000_0042);
        tick();
        in_valid = 1'b0;
        check("busy_e34_accept", 32'(in_ready), 32'd0);
        wait_done(n);
        check("busy2_latency", 32'(n), 32'd33);
        check("busy2_bcd", bcd_out, 32'h0000_0007);
        tick();

        // Result holds while idle.
        convert("c305", 32'd305, 32'h0000_0305, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick();
            check($sformatf("hold_bcd_%0d", i), bcd_out, 32'h0000_0305);
            check($sformatf("hold_valid_%0d", i), 32'(out_valid), 32'd0);
        end

        // Back-to-back conversions with in_valid held high.
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bin_in = WIDTH'(i);
            tick();
            wait_done(n);
            check($sformatf("stream_lat_%0d", i), 32'(n), 32'd33);
            check($sformatf("stream_bcd_%0d", i), bcd_out,
                  {24'h0, 4'(i / 10), 4'(i % 10)});
        end
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
